mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage sitting directly downstream of the execute stage's ALU.
- Accepts the ALU result (effective address or plain result), the store data and the load/store controls.
- Runs a request/grant/response transaction to data memory.
- Aligns store data, extracts and sign/zero-extends load data, and presents one registered result per instruction to writeback.
- Stalls execute through a ready signal while a memory transaction is outstanding.

Parameters:
- ADDR_W, 12, data-memory byte-address width; mem_addr carries ADDR_W bits taken from ex_result[ADDR_W-1:0].

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage can accept; high only in IDLE
- ex_result  in  32  ALU result / effective address
- ex_storedata  in  32  rs2 value for stores
- ex_memread  in  1  load
- ex_memwrite  in  1  store; wins if both set
- ex_funct3  in  3  access size/sign
- ex_rd  in  5  destination register
- ex_regwrite  in  1  instruction writes rd
- mem_req  out  1  request valid; held until granted
- mem_we  out  1  1=store
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits zero
- mem_be  out  4  byte enables, stores only; 0 for loads
- mem_wdata  out  32  lane-aligned store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load word
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_data  out  32  result / extended load data
- wb_rd  out  5  destination register
- wb_regwrite  out  1  write enable to the register file
- wb_misalign  out  1  misaligned access flag, valid with wb_valid

Behaviour:
- Reset:
  - Reset is asynchronous and active-low.
  - Asserting rst_n=0 at any time, including mid-transaction, forces state IDLE.
  - All outputs go to 0 immediately, except ex_ready=1.
  - An abandoned request is simply dropped.
- States: IDLE, REQ, WAIT, RESP.
- IDLE, when ex_valid=1 and ex_ready=1, accepts and registers all ex_* fields, then:
  - Non-memory op: go to RESP. wb_data=ex_result, wb_regwrite=ex_regwrite. Latency is 1 cycle.
  - Misaligned op: go to RESP with wb_misalign=1 and wb_regwrite=0. No mem_req is issued. Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]!=0.
  - Aligned load or store: go to REQ.
- REQ:
  - mem_req=1, with mem_addr, mem_we, mem_be and mem_wdata held stable.
  - On mem_gnt=1: a store goes to RESP; a load goes to WAIT.
  - mem_gnt may stay low indefinitely.
- WAIT:
  - On mem_rvalid=1, mem_rdata is captured, extended and written to wb_data; go to RESP.
  - mem_rvalid in any other state is ignored.
  - mem_rvalid in the grant cycle itself is ignored; memory returns data no earlier than the cycle after grant.
- RESP:
  - wb_valid=1 for exactly one cycle, then return to IDLE.
  - ex_ready is low throughout, so there is no back-to-back acceptance. Throughput is at most one instruction per 2 cycles.
- Store alignment:
  - SB (funct3 000): be=1<<addr[1:0]; wdata = byte replicated into all 4 lanes.
  - SH (funct3 001): be=0011 if addr[1]=0, else 1100; wdata = halfword replicated into both halves.
  - SW (funct3 010, and any other funct3): be=1111.
- Load extension (lane selected by addr[1:0]):
  - LB 000: sign-extended byte.
  - LH 001: sign-extended halfword.
  - LW 010: full word.
  - LBU 100: zero-extended byte.
  - LHU 101: zero-extended halfword.
  - 011/110/111: treated as LW.
- Store retire: wb_valid pulses with wb_regwrite=0.
- Load retire: wb_regwrite=ex_regwrite.
- Ignored inputs: ex_valid outside IDLE is ignored; execute holds its outputs while ex_ready=0.

Decomposition:
- Shared package mem_pkg:
  - Funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum: IDLE, REQ, WAIT, RESP.
  - Misalignment check function.
- Sub-module load_extend: combinational lane select plus sign/zero extension from (rdata, addr[1:0], funct3). Natural to split out; store alignment stays inline.

Test Plan:
- ALU pass-through: ex_result=0x0000_1234, rd=5, regwrite=1, no mem -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, mem_req never asserted.
- LB sign extension: addr=0x013, gnt on first REQ cycle, rvalid 2 cycles later with rdata=0x80AA_BBCC -> wb_data=0xFFFF_FF80; same stimulus as LBU -> 0x0000_0080; mem_addr=0x010.
- SH upper lane: addr=0x022, storedata=0x0000_BEEF, gnt held low 3 cycles -> mem_req high 4 cycles with stable outputs, be=1100, wdata=0xBEEF_BEEF, wb_valid with wb_regwrite=0.
- Misaligned LW: addr=0x006 -> no mem_req, next cycle wb_valid=1, wb_misalign=1, wb_regwrite=0.
- Reset mid-WAIT: load granted, rst_n low before rvalid -> outputs 0 immediately, ex_ready=1; late rvalid after reset ignored, no wb_valid.
- Stall: second ex_valid held during a load -> ex_ready=0 until the cycle after the wb_valid pulse, then the second instruction is accepted exactly once.

Source files
------------

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-access stage:
//   - funct3 access-size/sign encodings
//   - FSM state encoding
//   - misalignment check used at instruction acceptance
// ---------------------------------------------------------------------------
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   // Stores only know SB/SH, everything else is a word. Loads decode the
   // size from funct3[1:0] (B/BU byte, H/HU half, all remaining codes word).
   function automatic logic is_misaligned(input logic [2:0] f3,
                                          input logic       is_store,
                                          input logic [1:0] lane);
      logic half;
      logic word;
      if (is_store) begin
         half = (f3 == F3_H);
         word = (f3 != F3_B) && (f3 != F3_H);
      end else begin
         half = (f3[1:0] == 2'b01);
         word = f3[1];
      end
      return (half && lane[0]) || (word && (lane != 2'b00));
   endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational lane select and sign/zero extension of a loaded word.
// Ports:
//   i_rdata  [31:0] raw word returned by data memory
//   i_lane   [1:0]  byte offset of the access within the word
//   i_funct3 [2:0]  access size/sign
//   o_data   [31:0] extended value for writeback
// ---------------------------------------------------------------------------
module load_extend
   import mem_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_lane,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[{i_lane, 3'b000} +: 8];
      // Halfword accesses are aligned by the time data comes back, so only
      // lane[1] chooses the half.
      w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_funct3)
         F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
         F3_H:    o_data = {{16{w_half[15]}}, w_half};
         F3_BU:   o_data = {24'd0, w_byte};
         F3_HU:   o_data = {16'd0, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage. Accepts one instruction from execute while
// idle, performs a request/grant(/response) transaction to data memory for
// aligned loads and stores, and retires a single registered result to
// writeback. Execute is stalled (ex_ready=0) until the stage is idle again.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   ex_valid / ex_ready            handshake from execute
//   ex_result, ex_storedata        ALU result/effective address, store data
//   ex_memread, ex_memwrite        load / store (store wins if both)
//   ex_funct3, ex_rd, ex_regwrite  access size, destination, write enable
//   mem_req/we/addr/be/wdata       request to data memory, held until gnt
//   mem_gnt                        request accepted
//   mem_rvalid, mem_rdata          load data return
//   wb_valid                       one-cycle retire pulse
//   wb_data, wb_rd, wb_regwrite    writeback payload
//   wb_misalign                    misaligned access flag (with wb_valid)
// ---------------------------------------------------------------------------
module mem_stage
   import mem_pkg::*;
#(
   parameter int ADDR_W = 12
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [31:0]       ex_result,
   input  logic [31:0]       ex_storedata,
   input  logic              ex_memread,
   input  logic              ex_memwrite,
   input  logic [2:0]        ex_funct3,
   input  logic [4:0]        ex_rd,
   input  logic              ex_regwrite,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              wb_valid,
   output logic [31:0]       wb_data,
   output logic [4:0]        wb_rd,
   output logic              wb_regwrite,
   output logic              wb_misalign
);

   state_t              r_state, w_next;

   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [3:0]          r_be;
   logic [31:0]         r_wdata;
   logic [2:0]          r_f3;
   logic [1:0]          r_lane;
   logic [31:0]         r_wb_data;
   logic [4:0]          r_wb_rd;
   logic                r_wb_regwrite;
   logic                r_wb_misalign;

   logic                w_accept;
   logic                w_is_store;
   logic                w_is_load;
   logic                w_is_mem;
   logic                w_misalign;
   logic [3:0]          w_st_be;
   logic [31:0]         w_st_wdata;
   logic [31:0]         w_ld_data;

   // ------------------------------------------------------------------
   // Acceptance decode
   // ------------------------------------------------------------------
   assign w_accept   = ex_valid && (r_state == IDLE);
   assign w_is_store = ex_memwrite;
   assign w_is_load  = ex_memread && !ex_memwrite;
   assign w_is_mem   = w_is_store || w_is_load;
   assign w_misalign = w_is_mem &&
                       is_misaligned(ex_funct3, w_is_store, ex_result[1:0]);

   // Store lane alignment: narrow data is replicated so the byte enables
   // alone pick the target lane.
   always_comb begin
      case (ex_funct3)
         F3_B: begin
            w_st_be    = 4'b0001 << ex_result[1:0];
            w_st_wdata = {4{ex_storedata[7:0]}};
         end
         F3_H: begin
            w_st_be    = ex_result[1] ? 4'b1100 : 4'b0011;
            w_st_wdata = {2{ex_storedata[15:0]}};
         end
         default: begin
            w_st_be    = 4'b1111;
            w_st_wdata = ex_storedata;
         end
      endcase
   end

   load_extend u_load_extend (
      .i_rdata  (mem_rdata),
      .i_lane   (r_lane),
      .i_funct3 (r_f3),
      .o_data   (w_ld_data)
   );

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      ex_ready = 1'b0;
      mem_req  = 1'b0;
      wb_valid = 1'b0;
      case (r_state)
         IDLE: begin
            ex_ready = 1'b1;
            if (ex_valid)
               w_next = (w_is_mem && !w_misalign) ? REQ : RESP;
         end
         REQ: begin
            mem_req = 1'b1;
            if (mem_gnt) w_next = r_we ? RESP : WAIT;
         end
         WAIT: begin
            if (mem_rvalid) w_next = RESP;
         end
         RESP: begin
            wb_valid = 1'b1;
            w_next   = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we          <= 1'b0;
         r_addr        <= '0;
         r_be          <= 4'b0000;
         r_wdata       <= 32'd0;
         r_f3          <= 3'd0;
         r_lane        <= 2'd0;
         r_wb_data     <= 32'd0;
         r_wb_rd       <= 5'd0;
         r_wb_regwrite <= 1'b0;
         r_wb_misalign <= 1'b0;
      end else if (w_accept) begin
         r_we          <= w_is_store;
         r_addr        <= {ex_result[ADDR_W-1:2], 2'b00};
         r_be          <= w_is_store ? w_st_be : 4'b0000;
         r_wdata       <= w_is_store ? w_st_wdata : 32'd0;
         r_f3          <= ex_funct3;
         r_lane        <= ex_result[1:0];
         r_wb_rd       <= ex_rd;
         r_wb_misalign <= w_misalign;
         // Stores and faulting accesses never write the register file.
         r_wb_regwrite <= ex_regwrite && !w_is_store && !w_misalign;
         r_wb_data     <= w_is_mem ? 32'd0 : ex_result;
      end else if ((r_state == WAIT) && mem_rvalid) begin
         r_wb_data     <= w_ld_data;
      end
   end

   // ------------------------------------------------------------------
   // Outputs: request fields only driven while a request is live, and
   // writeback qualifiers only alongside the retire pulse.
   // ------------------------------------------------------------------
   assign mem_we      = mem_req && r_we;
   assign mem_addr    = mem_req ? r_addr  : '0;
   assign mem_be      = mem_req ? r_be    : 4'b0000;
   assign mem_wdata   = mem_req ? r_wdata : 32'd0;
   assign wb_data     = r_wb_data;
   assign wb_rd       = r_wb_rd;
   assign wb_regwrite = wb_valid && r_wb_regwrite;
   assign wb_misalign = wb_valid && r_wb_misalign;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ex_valid;
   logic              ex_ready;
   logic [31:0]       ex_result;
   logic [31:0]       ex_storedata;
   logic              ex_memread;
   logic              ex_memwrite;
   logic [2:0]        ex_funct3;
   logic [4:0]        ex_rd;
   logic              ex_regwrite;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;
   logic              wb_valid;
   logic [31:0]       wb_data;
   logic [4:0]        wb_rd;
   logic              wb_regwrite;
   logic              wb_misalign;

   int tests = 0;
   int fails = 0;

   mem_stage #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_result(ex_result), .ex_storedata(ex_storedata),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
      .wb_regwrite(wb_regwrite), .wb_misalign(wb_misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: access size in bytes from the architectural rules.
   function automatic int acc_size(input logic is_st, input logic [2:0] f3);
      if (is_st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction

   // Reference: loaded value seen by writeback.
   function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int lane, input logic [2:0] f3);
      logic [31:0] b, h;
      b = (rdata >> (8 * lane)) & 32'hFF;
      h = (rdata >> (8 * (lane & 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
         3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return rdata;
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw, input logic rden, input logic wren,
                         input logic [2:0] f3, input int gd, input int rdly, input logic [31:0] rdata);
      logic        is_st, is_ld, mis;
      int          sz, lane;
      logic [31:0] a, ebe, ewd, edata;
      is_st = wren;
      is_ld = rden && !wren;
      a     = res & 32'hFFF;
      lane  = int'(a % 4);
      sz    = acc_size(is_st, f3);
      mis   = (is_st || is_ld) && ((a % sz) != 0);
      ebe   = (sz == 4) ? 32'hF : (sz == 2) ? (32'h3 << lane) : (32'h1 << lane);
      ewd   = (sz == 4) ? sd : (sz == 2) ? (sd & 32'hFFFF) * 32'h0001_0001
                                          : (sd & 32'hFF) * 32'h0101_0101;
      for (int k = 0; k < 50 && ex_ready !== 1'b1; k++) step();
      chk({tag, ".ready"}, 32'(ex_ready), 32'd1);
      ex_valid = 1'b1; ex_result = res; ex_storedata = sd; ex_rd = rd;
      ex_regwrite = rw; ex_memread = rden; ex_memwrite = wren; ex_funct3 = f3;
      step();
      ex_valid = 1'b0;
      if ((is_st || is_ld) && !mis) begin
         for (int g = 0; g <= gd; g++) begin
            chk({tag, ".req"}, 32'(mem_req), 32'd1);
            chk({tag, ".addr"}, 32'(mem_addr), a & ~32'd3);
            chk({tag, ".we"}, 32'(mem_we), 32'(is_st));
            chk({tag, ".be"}, 32'(mem_be), is_st ? ebe : 32'd0);
            if (is_st) chk({tag, ".wdata"}, mem_wdata, ewd);
            chk({tag, ".stall"}, 32'(ex_ready), 32'd0);
            if (g == gd) begin
               mem_gnt = 1'b1;
               mem_rvalid = 1'b1;      // must be ignored in the grant cycle
               mem_rdata = ~rdata;
            end
            step();
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
         end
         if (is_ld) begin
            for (int w = 0; w < rdly; w++) begin
               chk({tag, ".wait_req"}, 32'(mem_req), 32'd0);
               chk({tag, ".wait_wb"}, 32'(wb_valid), 32'd0);
               step();
            end
            mem_rvalid = 1'b1;
            mem_rdata = rdata;
            step();
            mem_rvalid = 1'b0;
         end
      end
      chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
      chk({tag, ".wb_regwrite"}, 32'(wb_regwrite), 32'((is_st || mis) ? 1'b0 : rw));
      chk({tag, ".wb_misalign"}, 32'(wb_misalign), 32'(mis));
      chk({tag, ".resp_req"}, 32'(mem_req), 32'd0);
      chk({tag, ".resp_ready"}, 32'(ex_ready), 32'd0);
      if (!is_st && !mis) begin
         edata = is_ld ? ref_load(rdata, lane, f3) : res;
         chk({tag, ".wb_data"}, wb_data, edata);
      end
      step();
      chk({tag, ".pulse_end"}, 32'(wb_valid), 32'd0);
      chk({tag, ".idle_ready"}, 32'(ex_ready), 32'd1);
   endtask

   initial begin
      int npulse;
      logic rd_en, wr_en;
      rst_n = 1'b0; ex_valid = 1'b0; ex_result = '0; ex_storedata = '0;
      ex_memread = 1'b0; ex_memwrite = 1'b0; ex_funct3 = '0; ex_rd = '0;
      ex_regwrite = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      step(); step();
      chk("rst.ready", 32'(ex_ready), 32'd1);
      chk("rst.req", 32'(mem_req), 32'd0);
      chk("rst.wb_valid", 32'(wb_valid), 32'd0);
      chk("rst.wb_data", wb_data, 32'd0);
      chk("rst.addr", 32'(mem_addr), 32'd0);
      rst_n = 1'b1;
      step();

      // Directed cases
      run_op("alu", 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 0, 0, 32'h0);
      run_op("lb",  32'h0000_0013, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'd0, 0, 1, 32'h80AA_BBCC);
      run_op("lbu", 32'h0000_0013, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'd4, 0, 1, 32'h80AA_BBCC);
      run_op("sh",  32'h0000_0022, 32'h0000_BEEF, 5'd1, 1'b1, 1'b0, 1'b1, 3'd1, 3, 0, 32'h0);
      run_op("lw_mis", 32'h0000_0006, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'd2, 0, 0, 32'h0);
      run_op("sb", 32'h0000_0101, 32'h1234_56A5, 5'd2, 1'b1, 1'b0, 1'b1, 3'd0, 1, 0, 32'h0);
      run_op("both_st", 32'h0000_0040, 32'hDEAD_BEEF, 5'd6, 1'b1, 1'b1, 1'b1, 3'd2, 0, 0, 32'h0);
      run_op("lhu_hi", 32'h0000_0ABE, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'd5, 2, 3, 32'h9876_5432);

      // Reset in the middle of a load
      ex_valid = 1'b1; ex_result = 32'h40; ex_memread = 1'b1; ex_memwrite = 1'b0;
      ex_funct3 = 3'd2; ex_rd = 5'd11; ex_regwrite = 1'b1;
      step();
      ex_valid = 1'b0;
      chk("rstw.req", 32'(mem_req), 32'd1);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk("rstw.waiting", 32'(mem_req), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rstw.ready", 32'(ex_ready), 32'd1);
      chk("rstw.req0", 32'(mem_req), 32'd0);
      chk("rstw.wb_valid", 32'(wb_valid), 32'd0);
      chk("rstw.wb_rd", 32'(wb_rd), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
      step();
      mem_rvalid = 1'b0;
      npulse = 0;
      for (int c = 0; c < 3; c++) begin
         if (wb_valid === 1'b1) npulse++;
         step();
      end
      chk("rstw.late_rvalid", 32'(npulse), 32'd0);
      chk("rstw.wb_data", wb_data, 32'd0);

      // Stall: second instruction held on ex_valid during a load
      ex_valid = 1'b1; ex_result = 32'h100; ex_memread = 1'b1; ex_memwrite = 1'b0;
      ex_funct3 = 3'd0; ex_rd = 5'd7; ex_regwrite = 1'b1;
      step();
      ex_result = 32'h0000_CAFE; ex_memread = 1'b0; ex_rd = 5'd9;
      chk("stall.req_ready", 32'(ex_ready), 32'd0);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk("stall.wait_ready", 32'(ex_ready), 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_00FF;
      step();
      mem_rvalid = 1'b0;
      chk("stall.wb1_valid", 32'(wb_valid), 32'd1);
      chk("stall.wb1_data", wb_data, 32'hFFFF_FFFF);
      chk("stall.wb1_rd", 32'(wb_rd), 32'd7);
      chk("stall.resp_ready", 32'(ex_ready), 32'd0);
      step();
      chk("stall.idle_ready", 32'(ex_ready), 32'd1);
      chk("stall.idle_wb", 32'(wb_valid), 32'd0);
      step();
      ex_valid = 1'b0;
      chk("stall.wb2_valid", 32'(wb_valid), 32'd1);
      chk("stall.wb2_data", wb_data, 32'h0000_CAFE);
      chk("stall.wb2_rd", 32'(wb_rd), 32'd9);
      step();
      npulse = 0;
      for (int c = 0; c < 4; c++) begin
         if (wb_valid === 1'b1) npulse++;
         step();
      end
      chk("stall.once", 32'(npulse), 32'd0);

      // Randomized transactions
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0:       begin rd_en = 1'b0; wr_en = 1'b0; end
            1:       begin rd_en = 1'b1; wr_en = 1'b0; end
            2:       begin rd_en = 1'b0; wr_en = 1'b1; end
            default: begin rd_en = 1'(i % 2); wr_en = 1'b1; end
         endcase
         run_op($sformatf("rnd%0d", i), $urandom, $urandom, 5'($urandom), 1'($urandom),
                rd_en, wr_en, 3'($urandom_range(0, 7)), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule
